frontend_ctrl: RTL and testbench

Front-end pipeline controller that sequences the PC, BP/IF and IF/ID pipeline registers. It generates each register's `stall_current_stage`, `stall_next_stage` and `flush` controls from IF/decode back-pressure and backend redirects. It also issues the redirect PC to the PC generator. When a redirect arrives while an I-cache fetch is outstanding, it holds the front end in a drain state until the cache is idle, so stale fetch data never enters decode.

---
 rtl/frontend_ctrl_pkg.sv | 26 ++
 rtl/frontend_ctrl_if.sv | 71 +++++++
 rtl/frontend_ctrl.sv | 167 ++++++++++++++++
 tb/tb_frontend_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/frontend_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// frontend_ctrl_pkg
//
// Purpose: shared definitions for the front-end pipeline controller.
//    Holds the FSM state encoding and the default widths used by the
//    controller and by its interface.
//
// Contents:
//    FE_STATE_W   - width of the FSM state bus
//    fe_state_e   - FE_RUN / FE_DRAIN / FE_REFETCH
//    FE_ADDR_W    - default PC width
//    FE_CNT_W     - default width of the drain-cycle counter
// -----------------------------------------------------------------------------
package frontend_ctrl_pkg;

   localparam int FE_STATE_W = 2;
   localparam int FE_ADDR_W  = 32;
   localparam int FE_CNT_W   = 16;

   typedef enum logic [FE_STATE_W-1:0] {
      FE_RUN     = 2'd0,
      FE_DRAIN   = 2'd1,
      FE_REFETCH = 2'd2
   } fe_state_e;

endpackage : frontend_ctrl_pkg

// File: rtl/frontend_ctrl_if.sv
// -----------------------------------------------------------------------------
// frontend_ctrl_if
//
// Purpose: bundles the control and redirect signals between the front-end
//    controller and its environment (backend, I-cache, IF stage, decode
//    buffer, pipeline registers, PC generator).
//
// Handshake: redirect_valid is a one-cycle pulse qualifying redirect_pc;
//    there is no ready, a redirect is always accepted in the cycle it is
//    high. fetch_redirect_valid qualifies fetch_redirect_pc the same way;
//    fetch_redirect_pc reads 0 whenever fetch_redirect_valid is 0.
//
// Modports:
//    slave  - the controller (consumes redirect/back-pressure, drives controls)
//    master - the environment / testbench (the opposite directions)
// -----------------------------------------------------------------------------
interface frontend_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);

   // inputs to the controller
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  icache_busy;
   logic                  if_stall_req;
   logic                  ibuf_full;

   // outputs of the controller
   logic                  stall_pc;
   logic                  stall_bp_if;
   logic                  stall_if_id;
   logic                  flush_bp_if;
   logic                  flush_if_id;
   logic                  fetch_redirect_valid;
   logic [ADDR_WIDTH-1:0] fetch_redirect_pc;
   logic [CNT_WIDTH-1:0]  drain_cycles;

   modport slave (
      input  redirect_valid,
      input  redirect_pc,
      input  icache_busy,
      input  if_stall_req,
      input  ibuf_full,
      output stall_pc,
      output stall_bp_if,
      output stall_if_id,
      output flush_bp_if,
      output flush_if_id,
      output fetch_redirect_valid,
      output fetch_redirect_pc,
      output drain_cycles
   );

   modport master (
      output redirect_valid,
      output redirect_pc,
      output icache_busy,
      output if_stall_req,
      output ibuf_full,
      input  stall_pc,
      input  stall_bp_if,
      input  stall_if_id,
      input  flush_bp_if,
      input  flush_if_id,
      input  fetch_redirect_valid,
      input  fetch_redirect_pc,
      input  drain_cycles
   );

endinterface : frontend_ctrl_if

// File: rtl/frontend_ctrl.sv
// -----------------------------------------------------------------------------
// frontend_ctrl
//
// Purpose: front-end pipeline controller. Generates stall and flush controls
//    for the PC, BP/IF and IF/ID registers from IF/decode back-pressure and
//    backend redirects, and hands the redirect target to the PC generator.
//    A redirect that arrives while an I-cache fetch is outstanding parks the
//    front end in DRAIN (flushing every cycle) until the cache goes idle, then
//    issues the parked target from REFETCH, so stale fetch data never reaches
//    decode.
//
// Ports:
//    clk      - core clock
//    rst      - asynchronous active-low reset
//    fe       - frontend_ctrl_if.slave: redirect_valid/redirect_pc,
//               icache_busy, if_stall_req, ibuf_full in; stall_pc,
//               stall_bp_if, stall_if_id, flush_bp_if, flush_if_id,
//               fetch_redirect_valid/fetch_redirect_pc, drain_cycles out
//    state_o  - current FSM state (debug/observation)
//
// Stall and flush outputs are combinational from the inputs and the state.
// A flushed register loads a bubble; flush wins over stall at each register,
// so stall and flush may both be high in DRAIN.
// -----------------------------------------------------------------------------
module frontend_ctrl
   import frontend_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = FE_ADDR_W,
   parameter int CNT_WIDTH  = FE_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   frontend_ctrl_if.slave    fe,
   output fe_state_e         state_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   fe_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic [CNT_WIDTH-1:0]  drain_cnt_q, drain_cnt_d;

   // Combinational outputs
   logic                  stall_pc;
   logic                  stall_bp_if;
   logic                  stall_if_id;
   logic                  flush_bp_if;
   logic                  flush_if_id;
   logic                  fetch_redirect_valid;
   logic [ADDR_WIDTH-1:0] fetch_redirect_pc;

   logic                  back_pressure;

   assign back_pressure = fe.ibuf_full | fe.if_stall_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FE_RUN;
         pend_pc_q   <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_pc_q   <= pend_pc_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d              = state_q;
      pend_pc_d            = pend_pc_q;
      drain_cnt_d          = drain_cnt_q;
      stall_pc             = back_pressure;
      stall_bp_if          = back_pressure;
      stall_if_id          = fe.ibuf_full;
      flush_bp_if          = 1'b0;
      flush_if_id          = 1'b0;
      fetch_redirect_valid = 1'b0;
      fetch_redirect_pc    = '0;

      unique case (state_q)
         FE_RUN: begin
            if (fe.redirect_valid) begin
               flush_bp_if = 1'b1;
               flush_if_id = 1'b1;
               if (!fe.icache_busy) begin
                  // Zero-latency redirect: the PC must load the target even
                  // under back-pressure, otherwise the redirect is lost.
                  fetch_redirect_valid = 1'b1;
                  fetch_redirect_pc    = fe.redirect_pc;
                  stall_pc             = 1'b0;
               end else begin
                  pend_pc_d = fe.redirect_pc;
                  state_d   = FE_DRAIN;
               end
            end
         end

         FE_DRAIN: begin
            // Freeze PC and BP/IF, keep flushing so data returning from the
            // outstanding fetch is dropped. IF/ID is not stalled; it only
            // ever loads bubbles here.
            stall_pc    = 1'b1;
            stall_bp_if = 1'b1;
            stall_if_id = 1'b0;
            flush_bp_if = 1'b1;
            flush_if_id = 1'b1;
            if (drain_cnt_q != '1) begin
               drain_cnt_d = drain_cnt_q + CNT_ONE;
            end
            // Latest redirect wins.
            if (fe.redirect_valid) begin
               pend_pc_d = fe.redirect_pc;
            end
            if (!fe.icache_busy) begin
               state_d = FE_REFETCH;
            end
         end

         FE_REFETCH: begin
            state_d = FE_RUN;
            if (fe.redirect_valid) begin
               // A fresh redirect supersedes the parked target and is
               // handled exactly as in RUN.
               flush_bp_if = 1'b1;
               flush_if_id = 1'b1;
               if (!fe.icache_busy) begin
                  fetch_redirect_valid = 1'b1;
                  fetch_redirect_pc    = fe.redirect_pc;
                  stall_pc             = 1'b0;
               end else begin
                  pend_pc_d = fe.redirect_pc;
                  state_d   = FE_DRAIN;
               end
            end else begin
               // Issue the parked target; the PC must take it this cycle.
               fetch_redirect_valid = 1'b1;
               fetch_redirect_pc    = pend_pc_q;
               stall_pc             = 1'b0;
            end
         end

         default: begin
            state_d = FE_RUN;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output drive
   // ---------------------------------------------------------------------
   assign fe.stall_pc             = stall_pc;
   assign fe.stall_bp_if          = stall_bp_if;
   assign fe.stall_if_id          = stall_if_id;
   assign fe.flush_bp_if          = flush_bp_if;
   assign fe.flush_if_id          = flush_if_id;
   assign fe.fetch_redirect_valid = fetch_redirect_valid;
   assign fe.fetch_redirect_pc    = fetch_redirect_pc;
   assign fe.drain_cycles         = drain_cnt_q;
   assign state_o                 = state_q;

endmodule : frontend_ctrl

// File: tb/tb_frontend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frontend_ctrl
//
// Directed bench for frontend_ctrl with a 4-bit drain counter so saturation
// is reachable in a short run. Inputs change on the falling edge; outputs are
// sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_frontend_ctrl;
   import frontend_ctrl_pkg::*;

   localparam int AW = 32;
   localparam int CW = 4;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   frontend_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) fe_if ();
   fe_state_e state;

   frontend_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .fe      (fe_if),
      .state_o (state)
   );

   int n_vec;
   int n_err;

   // ---------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_ctl(input string tag,
                            input logic s_pc, input logic s_bpif, input logic s_ifid,
                            input logic f_bpif, input logic f_ifid,
                            input logic frv, input logic [31:0] frpc);
      check({tag, ".stall_pc"},    32'(fe_if.stall_pc),             32'(s_pc));
      check({tag, ".stall_bp_if"}, 32'(fe_if.stall_bp_if),          32'(s_bpif));
      check({tag, ".stall_if_id"}, 32'(fe_if.stall_if_id),          32'(s_ifid));
      check({tag, ".flush_bp_if"}, 32'(fe_if.flush_bp_if),          32'(f_bpif));
      check({tag, ".flush_if_id"}, 32'(fe_if.flush_if_id),          32'(f_ifid));
      check({tag, ".frv"},         32'(fe_if.fetch_redirect_valid), 32'(frv));
      check({tag, ".frpc"},        fe_if.fetch_redirect_pc,         frpc);
   endtask

   // ---------------------------------------------------------------------
   // Driver: apply one cycle of inputs on the falling edge, settle 1 ns
   // ---------------------------------------------------------------------
   task automatic drive(input logic rv, input logic [31:0] rpc, input logic busy,
                        input logic stall_req, input logic full);
      @(negedge clk);
      fe_if.redirect_valid = rv;
      fe_if.redirect_pc    = rpc;
      fe_if.icache_busy    = busy;
      fe_if.if_stall_req   = stall_req;
      fe_if.ibuf_full      = full;
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      fe_if.redirect_valid = 1'b0;
      fe_if.redirect_pc    = '0;
      fe_if.icache_busy    = 1'b0;
      fe_if.if_stall_req   = 1'b0;
      fe_if.ibuf_full      = 1'b0;

      // Reset with idle inputs
      drive(0, 32'h0, 0, 0, 0);
      drive(0, 32'h0, 0, 0, 0);
      check_ctl("reset", 0, 0, 0, 0, 0, 0, 32'h0);
      check("reset.state", 32'(state), 32'(FE_RUN));
      check("reset.cnt", 32'(fe_if.drain_cycles), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 32'h0, 0, 0, 0);
      check_ctl("idle", 0, 0, 0, 0, 0, 0, 32'h0);

      // Back-pressure only
      drive(0, 32'h0, 0, 0, 1);
      check_ctl("ibuf_full", 1, 1, 1, 0, 0, 0, 32'h0);
      drive(0, 32'h0, 0, 1, 0);
      check_ctl("if_stall", 1, 1, 0, 0, 0, 0, 32'h0);

      // Redirect with cache idle: same-cycle issue
      drive(1, 32'h8000_0100, 0, 0, 0);
      check_ctl("redir_idle", 0, 0, 0, 1, 1, 1, 32'h8000_0100);
      drive(0, 32'h0, 0, 0, 0);
      check("redir_idle.state", 32'(state), 32'(FE_RUN));
      check_ctl("after_redir", 0, 0, 0, 0, 0, 0, 32'h0);

      // Redirect together with ibuf_full: flush fires, PC not stalled
      drive(1, 32'h8000_0180, 0, 0, 1);
      check_ctl("redir_full", 0, 1, 1, 1, 1, 1, 32'h8000_0180);

      // Redirect with cache busy: three DRAIN cycles, busy low on the third
      drive(1, 32'h8000_0200, 1, 0, 0);
      check_ctl("redir_busy", 0, 0, 0, 1, 1, 0, 32'h0);
      check("redir_busy.state", 32'(state), 32'(FE_RUN));
      for (int i = 0; i < 3; i++) begin
         drive(0, 32'h0, (i < 2), 0, 0);
         check("drain.state", 32'(state), 32'(FE_DRAIN));
         check_ctl("drain", 1, 1, 0, 1, 1, 0, 32'h0);
      end
      drive(0, 32'h0, 0, 0, 0);
      check("refetch.state", 32'(state), 32'(FE_REFETCH));
      check_ctl("refetch", 0, 0, 0, 0, 0, 1, 32'h8000_0200);
      check("refetch.cnt", 32'(fe_if.drain_cycles), 32'd3);
      drive(0, 32'h0, 0, 0, 0);
      check("resume.state", 32'(state), 32'(FE_RUN));
      check_ctl("resume", 0, 0, 0, 0, 0, 0, 32'h0);

      // Second redirect during DRAIN: latest wins
      drive(1, 32'h8000_0280, 1, 0, 0);
      drive(1, 32'h8000_0300, 1, 0, 0);
      check("drain2.state", 32'(state), 32'(FE_DRAIN));
      drive(0, 32'h0, 0, 0, 0);
      check("drain2b.state", 32'(state), 32'(FE_DRAIN));
      drive(0, 32'h0, 0, 0, 0);
      check("refetch2.state", 32'(state), 32'(FE_REFETCH));
      check_ctl("refetch2", 0, 0, 0, 0, 0, 1, 32'h8000_0300);
      check("refetch2.cnt", 32'(fe_if.drain_cycles), 32'd5);

      // Redirect arriving in REFETCH with cache idle issues its own PC
      drive(1, 32'h8000_0500, 1, 0, 0);
      drive(0, 32'h0, 0, 0, 0);
      check("drain3.state", 32'(state), 32'(FE_DRAIN));
      drive(1, 32'h8000_0400, 0, 0, 0);
      check("refetch3.state", 32'(state), 32'(FE_REFETCH));
      check_ctl("refetch_redir", 0, 0, 0, 1, 1, 1, 32'h8000_0400);
      drive(0, 32'h0, 0, 0, 0);
      check("refetch3.next", 32'(state), 32'(FE_RUN));
      check_ctl("refetch3.quiet", 0, 0, 0, 0, 0, 0, 32'h0);
      check("refetch3.cnt", 32'(fe_if.drain_cycles), 32'd6);

      // Reset asserted mid-DRAIN
      drive(1, 32'h8000_0600, 1, 0, 0);
      drive(0, 32'h0, 1, 0, 0);
      check("pre_rst.state", 32'(state), 32'(FE_DRAIN));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst.state", 32'(state), 32'(FE_RUN));
      check("mid_rst.cnt", 32'(fe_if.drain_cycles), 32'd0);
      check_ctl("mid_rst", 0, 0, 0, 0, 0, 0, 32'h0);
      drive(0, 32'h0, 0, 0, 0);
      rst = 1'b1;
      drive(0, 32'h0, 0, 0, 0);
      check("post_rst.state", 32'(state), 32'(FE_RUN));
      check("post_rst.cnt", 32'(fe_if.drain_cycles), 32'd0);

      // Saturation: 20 busy DRAIN cycles on a 4-bit counter
      drive(1, 32'h8000_0700, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         drive(0, 32'h0, 1, 0, 0);
         if (i == 15 || i == 19) begin
            check("sat.cnt", 32'(fe_if.drain_cycles), 32'd15);
            check("sat.state", 32'(state), 32'(FE_DRAIN));
         end
      end
      drive(0, 32'h0, 0, 0, 0);
      check("sat_last.state", 32'(state), 32'(FE_DRAIN));
      drive(0, 32'h0, 0, 0, 0);
      check("sat_refetch.state", 32'(state), 32'(FE_REFETCH));
      check_ctl("sat_refetch", 0, 0, 0, 0, 0, 1, 32'h8000_0700);
      check("sat_refetch.cnt", 32'(fe_if.drain_cycles), 32'd15);
      drive(0, 32'h0, 0, 0, 0);
      check("sat_end.state", 32'(state), 32'(FE_RUN));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_frontend_ctrl
